// File: rtl/balance_pid_v2_if.sv
// Sample/handshake bundle for the balance PID: pitch samples in, scaled control word and status out.
interface balance_pid_v2_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 12
);
    logic                    vld;
    logic signed [IN_W-1:0]  ptch;
    logic signed [IN_W-1:0]  ptch_rt;
    logic                    pwr_up;
    logic                    rider_off;
    logic signed [OUT_W-1:0] cntrl_out;
    logic                    out_vld;
    logic [7:0]              ss_tmr;
    logic [1:0]              state;
    logic                    sat_flag;

    modport master (
        output vld, ptch, ptch_rt, pwr_up, rider_off,
        input  cntrl_out, out_vld, ss_tmr, state, sat_flag
    );

    modport slave (
        input  vld, ptch, ptch_rt, pwr_up, rider_off,
        output cntrl_out, out_vld, ss_tmr, state, sat_flag
    );
endinterface

// File: rtl/balance_pid_v2.sv
// Two-stage PID for the balance loop with anti-windup integrator and a soft-start
// output scaler driven by a power-up/power-down ramp state machine.
module balance_pid_v2 #(
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned P_COEFF    = 9,
    parameter int unsigned D_SHIFT    = 6,
    parameter int unsigned I_SHIFT    = 6,
    parameter int unsigned SS_DIV_LOG = 11
) (
    input logic              clk,
    input logic              rst_n,
    balance_pid_v2_if.slave  bus
);

    localparam int unsigned INT_W   = 18;
    localparam int unsigned P_W     = 15;
    localparam int unsigned D_W     = 13;
    localparam int unsigned I_W     = 15;
    localparam int unsigned PW      = (SS_DIV_LOG > 0) ? SS_DIV_LOG : 1;
    localparam int unsigned PRE_MAX = (1 << SS_DIV_LOG) - 1;

    localparam int ERR_MAX = 511;
    localparam int ERR_MIN = -512;
    localparam int D_MAX   = 4095;
    localparam int D_MIN   = -4096;
    localparam int I_MAX   = 16383;
    localparam int I_MIN   = -16384;
    localparam int INT_MAX = 131071;
    localparam int INT_MIN = -131072;
    localparam int OUT_MAX = (1 <<< (OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(1 <<< (OUT_W - 1));

    localparam logic [4:0] P_K5 = 5'(P_COEFF);

    typedef enum logic [1:0] {
        ST_OFF       = 2'b00,
        ST_RAMP_UP   = 2'b01,
        ST_RUN       = 2'b10,
        ST_RAMP_DOWN = 2'b11
    } state_e;

    function automatic int sat_i(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    state_e                  state_q, state_nxt;
    logic [7:0]              ss_q, ss_nxt;
    logic [PW-1:0]           pre_q, pre_nxt;
    logic                    tick;

    logic signed [INT_W-1:0] integ;
    logic signed [P_W-1:0]   p_q;
    logic signed [D_W-1:0]   d_q;
    logic signed [I_W-1:0]   i_q;
    logic                    s1_vld;
    logic signed [OUT_W-1:0] cntrl_q;
    logic                    out_vld_q;
    logic                    sat_flag_q;
    logic                    sum_neg_q;

    int   err_i, p_i, d_i, i_i, integ_add;
    int   sum_i, sat_sum_i, scaled_i;
    logic hold, integ_en;

    // Stage-1 terms, integrator update and stage-2 sum/saturate/scale
    always_comb begin
        err_i     = sat_i(int'(bus.ptch), ERR_MIN, ERR_MAX);
        p_i       = err_i * int'(P_K5);
        d_i       = sat_i(-(int'(bus.ptch_rt) >>> D_SHIFT), D_MIN, D_MAX);
        i_i       = sat_i(int'(integ) >>> I_SHIFT, I_MIN, I_MAX);
        integ_add = sat_i(int'(integ) + err_i, INT_MIN, INT_MAX);
        hold      = sat_flag_q && (err_i != 0) && ((err_i < 0) == sum_neg_q);
        integ_en  = bus.vld && !hold && ((state_q == ST_RAMP_UP) || (state_q == ST_RUN));
        sum_i     = int'(p_q) + int'(i_q) + int'(d_q);
        sat_sum_i = sat_i(sum_i, OUT_MIN, OUT_MAX);
        scaled_i  = (sat_sum_i * int'(ss_q)) >>> 8;
    end

    // Integrator: clear wins over a same-cycle sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ <= '0;
        end else if (bus.rider_off || (state_q == ST_OFF)) begin
            integ <= '0;
        end else if (integ_en) begin
            integ <= INT_W'(integ_add);
        end
    end

    // Two-stage datapath; I term uses the integrator value before this edge's update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            d_q        <= '0;
            i_q        <= '0;
            s1_vld     <= 1'b0;
            cntrl_q    <= '0;
            out_vld_q  <= 1'b0;
            sat_flag_q <= 1'b0;
            sum_neg_q  <= 1'b0;
        end else begin
            s1_vld    <= bus.vld;
            out_vld_q <= s1_vld;
            if (bus.vld) begin
                p_q <= P_W'(p_i);
                d_q <= D_W'(d_i);
                i_q <= I_W'(i_i);
            end
            if (s1_vld) begin
                cntrl_q    <= OUT_W'(scaled_i);
                sat_flag_q <= (sum_i != sat_sum_i);
                sum_neg_q  <= (sat_sum_i < 0);
            end
        end
    end

    // Soft-start state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            ss_q    <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_nxt;
            ss_q    <= ss_nxt;
            pre_q   <= pre_nxt;
        end
    end

    // Soft-start next state; the prescaler restarts on any state change
    always_comb begin
        state_nxt = state_q;
        ss_nxt    = ss_q;
        tick      = (pre_q == PW'(PRE_MAX));
        pre_nxt   = tick ? '0 : pre_q + PW'(1);
        unique case (state_q)
            ST_OFF: begin
                ss_nxt = '0;
                if (bus.pwr_up) state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (tick && (ss_q != 8'd255)) ss_nxt = ss_q + 8'd1;
                if (!bus.pwr_up)              state_nxt = ST_RAMP_DOWN;
                else if (ss_nxt == 8'd255)    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.pwr_up) state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (tick && (ss_q != 8'd0)) ss_nxt = ss_q - 8'd1;
                if (bus.pwr_up)             state_nxt = ST_RAMP_UP;
                else if (ss_nxt == 8'd0)    state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
        if (state_nxt != state_q) pre_nxt = '0;
    end

    assign bus.cntrl_out = cntrl_q;
    assign bus.out_vld   = out_vld_q;
    assign bus.ss_tmr    = ss_q;
    assign bus.state     = state_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_balance_pid_v2.sv
// Directed bench for balance_pid_v2: scoreboarded samples with a reference model,
// ramp sequencing, integrator clamp/anti-windup and reset behaviour.
module tb_balance_pid_v2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_vec;
    int   n_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    balance_pid_v2_if #(.IN_W(16), .OUT_W(12)) bus ();

    balance_pid_v2 #(
        .IN_W(16), .OUT_W(12), .P_COEFF(9), .D_SHIFT(6), .I_SHIFT(6), .SS_DIV_LOG(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int   exp_cyc;
        int   cntrl;
        logic sat;
    } ent_t;

    ent_t sb[$];

    // Reference model state
    int m_integ;
    bit m_sat;
    bit m_neg;

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and push its expected result
    task automatic send(input int p, input int r, input bit rider, input bit run, input int ss2);
        int   err, pt, dt, it, sum, ssum;
        ent_t e;
        err  = clamp(p, -512, 511);
        pt   = err * 9;
        dt   = clamp(-(r >>> 6), -4096, 4095);
        it   = clamp(m_integ >>> 6, -16384, 16383);
        sum  = pt + dt + it;
        ssum = clamp(sum, -2048, 2047);
        e.exp_cyc = cyc + 2;
        e.cntrl   = (ssum * ss2) >>> 8;
        e.sat     = (sum != ssum);
        sb.push_back(e);
        if (rider || !run) m_integ = 0;
        else if (!(m_sat && err != 0 && ((err < 0) == m_neg)))
            m_integ = clamp(m_integ + err, -131072, 131071);
        m_sat = e.sat;
        m_neg = (ssum < 0);
        bus.ptch      = 16'(p);
        bus.ptch_rt   = 16'(r);
        bus.rider_off = rider;
        bus.vld       = 1'b1;
    endtask

    task automatic idle();
        bus.vld       = 1'b0;
        bus.rider_off = 1'b0;
    endtask

    task automatic pulse(input int p, input int r);
        send(p, r, 1'b0, 1'b1, 255);
        step();
        idle();
        repeat (4) step();
    endtask

    // Output monitor: every strobe must match the oldest expected sample
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && bus.out_vld) begin
                if (sb.size() == 0) begin
                    chk("out_vld_unexpected", 32'(bus.out_vld), 32'sd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.exp_cyc));
                    chk("cntrl_out", 32'(bus.cntrl_out), 32'(e.cntrl));
                    chk("sat_flag", 32'(bus.sat_flag), 32'(e.sat));
                end
            end
        end
    end

    initial begin
        bus.vld = 1'b0; bus.ptch = '0; bus.ptch_rt = '0;
        bus.pwr_up = 1'b1; bus.rider_off = 1'b0;
        m_integ = 0; m_sat = 1'b0; m_neg = 1'b0;

        // Reset state
        #12;
        chk("rst_state", 32'(bus.state), 32'sd0);
        chk("rst_ss", 32'(bus.ss_tmr), 32'sd0);
        chk("rst_cntrl", 32'(bus.cntrl_out), 32'sd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'sd0);
        chk("rst_integ", 32'(dut.integ), 32'sd0);

        // Ramp up, with one sample scaled by a mid-ramp ss_tmr
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ramp_state1", 32'(bus.state), 32'sd1);
        chk("ramp_ss1", 32'(bus.ss_tmr), 32'sd0);
        repeat (99) step();
        chk("ramp_ss99", 32'(bus.ss_tmr), 32'sd99);
        send(16, 0, 1'b0, 1'b1, 100);
        step();
        idle();
        repeat (155) step();
        chk("run_state", 32'(bus.state), 32'sd2);
        chk("run_ss", 32'(bus.ss_tmr), 32'sd255);
        chk("integ_ramp", 32'(dut.integ), 32'(m_integ));

        // rider_off alone clears the integrator
        bus.rider_off = 1'b1;
        step();
        bus.rider_off = 1'b0;
        m_integ = 0;
        chk("rider_clear", 32'(dut.integ), 32'sd0);

        // Basic arithmetic and mixed-sign patterns
        pulse(16, 0);
        chk("integ_16", 32'(dut.integ), 32'sd16);
        pulse(-300, 1000);
        pulse(100, -5000);
        chk("integ_mix", 32'(dut.integ), 32'(m_integ));

        // Saturation; integrator frozen after the first saturating sample
        pulse(28672, 0);
        chk("integ_sat1", 32'(dut.integ), 32'(m_integ));
        pulse(28672, 0);
        pulse(28672, 0);
        chk("integ_frozen", 32'(dut.integ), 32'(m_integ));

        // Build integrator to 1000, then rider_off together with a sample
        bus.rider_off = 1'b1;
        step();
        bus.rider_off = 1'b0;
        m_integ = 0;
        pulse(0, 0);
        repeat (5) pulse(200, 0);
        chk("integ_1000", 32'(dut.integ), 32'sd1000);
        send(16, 0, 1'b1, 1'b1, 255);
        step();
        idle();
        chk("rider_vld_clear", 32'(dut.integ), 32'sd0);
        repeat (4) step();

        // Drive integrator to -131000 with back-to-back unsaturated samples
        for (int i = 0; i < 2339; i++) begin
            send(-56, -32768, 1'b0, 1'b1, 255);
            step();
        end
        send(-16, -32768, 1'b0, 1'b1, 255);
        step();
        chk("integ_m131000", 32'(dut.integ), -32'sd131000);
        for (int i = 0; i < 20; i++) begin
            send(-32768, 0, 1'b0, 1'b1, 255);
            step();
            chk("integ_clamp", 32'(dut.integ), -32'sd131072);
        end
        idle();
        repeat (5) step();

        // Ramp down, resume upward, then down to OFF
        bus.pwr_up = 1'b0;
        step();
        chk("down_state", 32'(bus.state), 32'sd3);
        repeat (55) step();
        chk("down_ss200", 32'(bus.ss_tmr), 32'sd200);
        bus.pwr_up = 1'b1;
        step();
        chk("resume_state", 32'(bus.state), 32'sd1);
        for (int i = 0; i < 300 && bus.state != 2'd2; i++) step();
        chk("resume_run", 32'(bus.state), 32'sd2);
        chk("resume_ss", 32'(bus.ss_tmr), 32'sd255);
        bus.pwr_up = 1'b0;
        for (int i = 0; i < 300 && bus.state != 2'd0; i++) step();
        chk("off_state", 32'(bus.state), 32'sd0);
        chk("off_ss", 32'(bus.ss_tmr), 32'sd0);
        step();
        chk("off_integ", 32'(dut.integ), 32'sd0);
        m_integ = 0;

        // Back to RUN, then reset with the pipeline full
        bus.pwr_up = 1'b1;
        for (int i = 0; i < 300 && bus.state != 2'd2; i++) step();
        chk("rerun_state", 32'(bus.state), 32'sd2);
        send(16, 0, 1'b0, 1'b1, 255);
        step();
        send(16, 0, 1'b0, 1'b1, 255);
        step();
        send(16, 0, 1'b0, 1'b1, 255);
        step();
        #2;
        rst_n = 1'b0;
        sb.delete();
        idle();
        bus.pwr_up = 1'b0;
        #1;
        chk("mid_rst_out_vld", 32'(bus.out_vld), 32'sd0);
        chk("mid_rst_cntrl", 32'(bus.cntrl_out), 32'sd0);
        chk("mid_rst_state", 32'(bus.state), 32'sd0);
        chk("mid_rst_ss", 32'(bus.ss_tmr), 32'sd0);
        chk("mid_rst_integ", 32'(dut.integ), 32'sd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_integ = 0; m_sat = 1'b0; m_neg = 1'b0;
        repeat (5) step();
        chk("post_rst_state", 32'(bus.state), 32'sd0);

        // Pipeline still runs in OFF with zero scale
        send(16, 0, 1'b0, 1'b0, 0);
        step();
        idle();
        repeat (5) step();
        chk("off_vld_integ", 32'(dut.integ), 32'sd0);
        chk("sb_drained", 32'(sb.size()), 32'sd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
